// File: rtl/axis_latency_probe_if.sv
// ---------------------------------------------------------------------------
// axis_latency_probe_if
//   AXI-Stream beat bundle without backpressure (no tready).
//   Ports / signals:
//     tdata   DATA_WIDTH  beat payload
//     tvalid  1           beat valid
//     tlast   1           beat last
//   Modports:
//     master  drives the beat (transmit side)
//     slave   receives the beat (receive side)
// ---------------------------------------------------------------------------
interface axis_latency_probe_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast);
    modport slave  (input  tdata, input  tvalid, input  tlast);
endinterface

// File: rtl/axis_latency_probe.sv
// ---------------------------------------------------------------------------
// axis_latency_probe
//   Round-trip latency calibration. On start, sends one marker beat on m_axis,
//   counts cycles until the marker returns on s_axis, and reports the count.
//   Ports:
//     clk            clock
//     rst            synchronous active-high reset
//     start          single-cycle measurement request (ignored while busy)
//     m_axis         probe stream toward the path under test (master)
//     s_axis         returned stream from the path (slave)
//     latency        measured cycles, held until the next start
//     latency_valid  level; latency holds a valid result
//     timeout        level; last measurement expired without a match
//     busy           measurement in progress (SEND or WAIT)
// ---------------------------------------------------------------------------
module axis_latency_probe #(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] MARKER      = 'hA5A5,
    parameter int                    COUNT_WIDTH = 16,
    parameter int                    TIMEOUT     = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    axis_latency_probe_if.master   m_axis,
    axis_latency_probe_if.slave    s_axis,
    output logic [COUNT_WIDTH-1:0] latency,
    output logic                   latency_valid,
    output logic                   timeout,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_CNT = COUNT_WIDTH'(TIMEOUT);

    state_t                  state_q,         state_d;
    logic [COUNT_WIDTH-1:0]  count_q,         count_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q,       m_tdata_d;
    logic                    m_tvalid_q,      m_tvalid_d;
    logic                    m_tlast_q,       m_tlast_d;
    logic [COUNT_WIDTH-1:0]  latency_q,       latency_d;
    logic                    latency_valid_q, latency_valid_d;
    logic                    timeout_q,       timeout_d;
    logic                    busy_q,          busy_d;
    logic                    match;

    // Only a complete, last-flagged marker beat counts as the returned probe.
    assign match = s_axis.tvalid && s_axis.tlast && (s_axis.tdata == MARKER);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        count_d         = '0;
        m_tdata_d       = '0;
        m_tvalid_d      = 1'b0;
        m_tlast_d       = 1'b0;
        latency_d       = latency_q;
        latency_valid_d = latency_valid_q;
        timeout_d       = timeout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d         = SEND;
                    m_tdata_d       = MARKER;
                    m_tvalid_d      = 1'b1;
                    m_tlast_d       = 1'b1;
                    latency_d       = '0;
                    latency_valid_d = 1'b0;
                    timeout_d       = 1'b0;
                end
            end
            SEND: begin
                // Counter is 0 here, so a same-cycle (combinational) return
                // reports zero latency.
                if (match) begin
                    latency_d       = '0;
                    latency_valid_d = 1'b1;
                    state_d         = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A match on the final permitted cycle still wins over timeout.
                if (match) begin
                    latency_d       = count_q;
                    latency_valid_d = 1'b1;
                    state_d         = DONE;
                end else if (count_q == TIMEOUT_CNT) begin
                    latency_d       = '1;
                    latency_valid_d = 1'b0;
                    timeout_d       = 1'b1;
                    state_d         = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SEND) || (state_d == WAIT);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q         <= IDLE;
            count_q         <= '0;
            m_tdata_q       <= '0;
            m_tvalid_q      <= 1'b0;
            m_tlast_q       <= 1'b0;
            latency_q       <= '0;
            latency_valid_q <= 1'b0;
            timeout_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            m_tdata_q       <= m_tdata_d;
            m_tvalid_q      <= m_tvalid_d;
            m_tlast_q       <= m_tlast_d;
            latency_q       <= latency_d;
            latency_valid_q <= latency_valid_d;
            timeout_q       <= timeout_d;
            busy_q          <= busy_d;
        end
    end

    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign latency       = latency_q;
    assign latency_valid = latency_valid_q;
    assign timeout       = timeout_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_axis_latency_probe.sv
// ---------------------------------------------------------------------------
// tb_axis_latency_probe
//   Scoreboard bench for axis_latency_probe (TIMEOUT = 20). The stimulus
//   pushes the expected probe beat and expected result before each launch;
//   a monitor pops and compares when the DUT emits a probe beat or drops busy.
//   The return path is a wire loopback, a registered delay line, a manually
//   driven stream, or silence.
// ---------------------------------------------------------------------------
module tb_axis_latency_probe;

    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int TMO = 20;
    localparam logic [DW-1:0] MK = 16'hA5A5;

    typedef enum int {M_WIRE, M_DELAY, M_MANUAL, M_NONE} mode_t;

    typedef struct {
        logic [CW-1:0] lat;
        logic          vld;
        logic          tmo;
        int            end_off;  // cycles from probe beat to busy low
    } result_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [CW-1:0] latency;
    logic latency_valid, timeout, busy;

    axis_latency_probe_if #(.DATA_WIDTH(DW)) m_if ();
    axis_latency_probe_if #(.DATA_WIDTH(DW)) s_if ();

    axis_latency_probe #(
        .DATA_WIDTH (DW),
        .MARKER     (MK),
        .COUNT_WIDTH(CW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .m_axis       (m_if.master),
        .s_axis       (s_if.slave),
        .latency      (latency),
        .latency_valid(latency_valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Return path
    mode_t          mode;
    logic [4:0]     depth_m1;
    logic [DW+1:0]  dl [32];
    logic [DW-1:0]  man_tdata;
    logic           man_tvalid, man_tlast;

    always @(posedge clk) begin
        dl[0] <= {m_if.tdata, m_if.tvalid, m_if.tlast};
        for (int i = 1; i < 32; i++) dl[i] <= dl[i-1];
    end

    always_comb begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        case (mode)
            M_WIRE:   {s_if.tdata, s_if.tvalid, s_if.tlast} = {m_if.tdata, m_if.tvalid, m_if.tlast};
            M_DELAY:  {s_if.tdata, s_if.tvalid, s_if.tlast} = dl[depth_m1];
            M_MANUAL: {s_if.tdata, s_if.tvalid, s_if.tlast} = {man_tdata, man_tvalid, man_tlast};
            default: ;
        endcase
    end

    // Scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] probe_q [$];
    result_t       exp_q   [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin : monitor
        int      probe_cyc;
        logic    prev_busy;
        result_t r;
        logic [DW-1:0] pd;
        probe_cyc = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (m_if.tvalid === 1'b1) begin
                if (probe_q.size() == 0) begin
                    check("unexpected_probe_beat", 32'd1, 32'd0);
                end else begin
                    pd = probe_q.pop_front();
                    probe_cyc = cyc;
                    check("probe_tdata", 32'(m_if.tdata), 32'(pd));
                    check("probe_tlast", 32'(m_if.tlast), 32'd1);
                    check("probe_busy", 32'(busy), 32'd1);
                    check("probe_latency_cleared", 32'(latency), 32'd0);
                    check("probe_valid_cleared", 32'(latency_valid), 32'd0);
                    check("probe_timeout_cleared", 32'(timeout), 32'd0);
                end
            end
            if (prev_busy === 1'b1 && busy === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    check("result_latency", 32'(latency), 32'(r.lat));
                    check("result_valid", 32'(latency_valid), 32'(r.vld));
                    check("result_timeout", 32'(timeout), 32'(r.tmo));
                    check("result_cycle_offset", 32'(cyc - probe_cyc), 32'(r.end_off));
                end
            end
            prev_busy = busy;
        end
    end

    // Stimulus helpers
    task automatic expect_run(input logic [CW-1:0] lat, input logic vld, input logic tmo, input int off);
        result_t r;
        r.lat = lat; r.vld = vld; r.tmo = tmo; r.end_off = off;
        probe_q.push_back(MK);
        exp_q.push_back(r);
    endtask

    // Ends at the falling edge inside cycle c0 (probe beat visible).
    task automatic launch();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);  // drain the delay line
    endtask

    task automatic run_delay(input int d, input logic [CW-1:0] lat, input logic vld,
                             input logic tmo, input int off);
        mode = M_DELAY;
        depth_m1 = 5'(d - 1);
        expect_run(lat, vld, tmo, off);
        launch();
        wait_idle(60);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = M_NONE; depth_m1 = '0;
        man_tdata = '0; man_tvalid = 1'b0; man_tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_m_tdata", 32'(m_if.tdata), 32'd0);
        check("reset_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("reset_m_tlast", 32'(m_if.tlast), 32'd0);
        check("reset_latency", 32'(latency), 32'd0);
        check("reset_latency_valid", 32'(latency_valid), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1. Direct wire loopback: latency 0, busy for exactly one cycle.
        mode = M_WIRE;
        expect_run(16'd0, 1'b1, 1'b0, 1);
        launch();
        wait_idle(60);

        // 2. 10-stage delay line.
        run_delay(10, 16'd10, 1'b1, 1'b0, 11);

        // 3. No return: timeout visible at c0+21, latency all-ones.
        mode = M_NONE;
        expect_run(16'hFFFF, 1'b0, 1'b1, TMO + 1);
        launch();
        wait_idle(60);

        // 4. Fresh start after timeout, delay 5.
        run_delay(5, 16'd5, 1'b1, 1'b0, 6);

        // 5. Distractors at offsets 2 and 3, marker at 7, extra starts while busy.
        mode = M_MANUAL;
        expect_run(16'd7, 1'b1, 1'b0, 8);
        launch();                                        // now in c0 (SEND)
        start = 1'b1;                                    // sampled in SEND
        @(negedge clk); start = 1'b0;                    // c0+1
        @(negedge clk);                                  // c0+2
        man_tdata = 16'hA5A4; man_tvalid = 1'b1; man_tlast = 1'b1;
        @(negedge clk);                                  // c0+3
        man_tdata = 16'hA5A5; man_tvalid = 1'b1; man_tlast = 1'b0;
        start = 1'b1;                                    // sampled in WAIT
        @(negedge clk);                                  // c0+4
        man_tdata = '0; man_tvalid = 1'b0; man_tlast = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);                       // c0+7
        man_tdata = MK; man_tvalid = 1'b1; man_tlast = 1'b1;
        @(negedge clk);                                  // c0+8
        man_tdata = '0; man_tvalid = 1'b0; man_tlast = 1'b0;
        wait_idle(60);

        // 6. Marker exactly at counter == TIMEOUT: match wins.
        run_delay(20, 16'd20, 1'b1, 1'b0, 21);

        // 7. Reset at offset 4 of a delay-10 measurement.
        mode = M_DELAY;
        depth_m1 = 5'd9;
        expect_run(16'd0, 1'b0, 1'b0, 5);
        launch();                                        // c0
        repeat (4) @(negedge clk);                       // c0+4
        rst = 1'b1;
        @(negedge clk);                                  // c0+5
        rst = 1'b0;
        check("abort_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("abort_m_tdata", 32'(m_if.tdata), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_latency", 32'(latency), 32'd0);
        check("abort_timeout", 32'(timeout), 32'd0);
        repeat (7) @(negedge clk);                       // c0+12, marker returned at c0+10
        check("abort_ignores_return_valid", 32'(latency_valid), 32'd0);
        check("abort_ignores_return_latency", 32'(latency), 32'd0);
        check("abort_stays_idle", 32'(busy), 32'd0);
        repeat (25) @(negedge clk);

        check("probe_queue_drained", 32'(probe_q.size()), 32'd0);
        check("result_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_latency_probe.md
# axis_latency_probe

Round-trip latency calibration block for an AXI-Stream datapath without backpressure (no tready). It injects a single marker beat on its transmit stream, watches its receive stream for that marker, and reports the elapsed cycle count. It sits at both ends of a fixed-latency section, such as a delay line, an analog/photonic loopback or a DAC→ADC path, and calibrates the timing offsets that downstream alignment logic uses.

## Interface
- DATA_WIDTH, 16, width of probe and return tdata
- MARKER, 16'hA5A5, probe pattern (DATA_WIDTH bits)
- COUNT_WIDTH, 16, width of cycle counter and latency result
- TIMEOUT, 1000, maximum cycles to wait; must satisfy TIMEOUT < 2^COUNT_WIDTH
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to launch a measurement
- m_axis_tdata  out  DATA_WIDTH  probe data toward the path under test
- m_axis_tvalid  out  1  probe beat valid
- m_axis_tlast  out  1  probe beat last
- s_axis_tdata  in  DATA_WIDTH  returned stream from the path
- s_axis_tvalid  in  1  returned beat valid
- s_axis_tlast  in  1  returned beat last
- latency  out  COUNT_WIDTH  measured cycles, held until the next start
- latency_valid  out  1  level; result in latency is valid
- timeout  out  1  level; the last measurement expired without a match
- busy  out  1  measurement in progress

## Operation
- States: IDLE, SEND, WAIT, DONE.
- IDLE: m_axis outputs are 0 and the counter is 0. `start`=1 moves the block to SEND and clears latency_valid, timeout and latency.
- SEND lasts exactly one cycle. It drives m_axis_tdata=MARKER, tvalid=1, tlast=1, and counter=0. It then moves to WAIT.
- WAIT increments the counter by 1 each cycle. m_axis outputs are 0.
- A match is s_axis_tvalid && s_axis_tlast && s_axis_tdata==MARKER. A match is checked in both SEND and WAIT.
  - Match in SEND (combinational loopback) gives latency=0.
  - Match in WAIT gives latency = the current counter value.
  - On a match: latency is loaded, latency_valid=1, and the state moves to DONE.
- Beats that do not match (wrong data, tlast=0, or tvalid=0) are ignored. Only the first match counts.
- Timeout: in WAIT with counter==TIMEOUT and no match, the block sets timeout=1, latency=all-ones, latency_valid=0, and moves to DONE. A match in that same cycle wins: latency=TIMEOUT and timeout=0.
- DONE holds the results. A new `start` re-launches the measurement (to SEND) with the same clears as in IDLE.
- `start` while busy (SEND/WAIT) is ignored.
- Matches seen in IDLE or DONE are ignored.
- busy=1 in SEND and WAIT, 0 otherwise.

## Timing
- All outputs are registered.
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, latency=0, latency_valid=0, timeout=0, busy=0, state IDLE.
- Reset mid-measurement aborts immediately: the next cycle shows the reset values, and no result is produced.
- `start` is sampled at edge e. The probe beat is on m_axis in the cycle after e (cycle c0), and busy is high in that same cycle.
- A return beat sampled at the end of cycle c1 gives latency = c1 − c0.
- latency and latency_valid (or timeout) update at that same edge and are visible from cycle c1+1. busy drops in cycle c1+1.
- Definition: a path of N registers between m_axis and s_axis reports latency=N. Loopback through a 10-stage register delay reports 10.
- Each measurement emits exactly one probe beat. The counter never wraps, because of the TIMEOUT bound.

## Test plan
- Direct wire loopback (s_axis = m_axis), start pulse → latency=0, latency_valid=1 one cycle after the probe, timeout=0, busy high for 1 cycle.
- Loopback through a 10-stage registered delay line, start → exactly one m_axis beat (tdata=16'hA5A5, tlast=1), latency=10, latency_valid=1.
- No return with TIMEOUT=20 → timeout=1 at cycle c0+21, latency=16'hFFFF, latency_valid=0. Then a delay-5 loopback with a fresh start → latency=5, timeout=0.
- Distractor beats on s_axis (16'hA5A4 with tlast=1, 16'hA5A5 with tlast=0) at offsets 2 and 3, marker at offset 7 → latency=7. Extra start pulses during WAIT produce no additional probe.
- Marker arrives exactly at counter==TIMEOUT (TIMEOUT=20, delay 20) → latency=20, latency_valid=1, timeout=0.
- rst asserted at offset 4 of a delay-10 measurement → all outputs at reset values next cycle, and the returning marker at offset 10 is ignored (latency_valid stays 0).
